// File: rtl/half_img_merge.sv
// Rebuilds one full-width side-by-side line from paired left/right half-width streams.
// Optional HALF_MERGE_SEAM_EN: first right-half output pixel of each line forced to all ones.
module half_img_merge #(
  parameter int HALF_IMG_W = 640,
  parameter int PX_WIDTH   = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                de_in,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  input  logic [PX_WIDTH-1:0] pixel_left,
  input  logic [PX_WIDTH-1:0] pixel_right,
  output logic                de_out,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic [PX_WIDTH-1:0] pixel_out,
  output logic                line_err
);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(HALF_IMG_W);

  state_t              state;
  logic                de_in_p1;
  logic                ovf_p1;
  logic                sel_right_p1;
  logic                vld_p1;
  logic                err_p1;
  logic                hs_p1;
  logic                vs_p1;
  logic                seam_p1;
  logic [ADDR_W:0]     wr_cnt;
  logic [ADDR_W:0]     rd_cnt;
  logic [ADDR_W:0]     len;
  logic [PX_WIDTH-1:0] left_p1;
  logic [PX_WIDTH-1:0] ram_q;
  logic [PX_WIDTH-1:0] mem [2**ADDR_W];
  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic [ADDR_W-1:0]   ra;
  logic                rise;

  function automatic logic [PX_WIDTH-1:0] right_px(input logic [PX_WIDTH-1:0] px,
                                                  input logic first);
`ifdef HALF_MERGE_SEAM_EN
    right_px = first ? {PX_WIDTH{1'b1}} : px;
`else
    right_px = (first & 1'b0) ? '0 : px;
`endif
  endfunction

  assign rise = de_in & ~de_in_p1;

  // Buffer ports; a write also marks the cycle in which a left pixel is accepted.
  // Read address 0 is held outside RIGHT so the first right pixel is ready on the falling edge.
  always_comb begin
    we = 1'b0;
    wa = wr_cnt[ADDR_W-1:0];
    ra = '0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          we = 1'b1;
          wa = '0;
        end
      end
      LEFT: begin
        if (de_in && (wr_cnt < MAX_CNT)) we = 1'b1;
      end
      RIGHT: begin
        ra = rd_cnt[ADDR_W-1:0];
        if (rise) begin
          we = 1'b1;
          wa = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= pixel_right;
  end

  // Stage p1: buffer read data and accepted left pixel
  always_ff @(posedge clk) begin
    ram_q <= mem[ra];
    if (we) left_p1 <= pixel_left;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      de_in_p1     <= 1'b1;
      ovf_p1       <= 1'b0;
      sel_right_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
      hs_p1        <= 1'b0;
      vs_p1        <= 1'b0;
      seam_p1      <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      len          <= '0;
    end else begin
      de_in_p1 <= de_in;
      hs_p1    <= h_sync_in;
      vs_p1    <= v_sync_in;
      err_p1   <= 1'b0;
      seam_p1  <= 1'b0;
      if (rise && (state != LEFT)) begin
        // A rise during an unfinished right readout is a collision; the new line wins.
        state        <= LEFT;
        wr_cnt       <= (ADDR_W+1)'(1);
        ovf_p1       <= 1'b0;
        vld_p1       <= 1'b1;
        sel_right_p1 <= 1'b0;
        err_p1       <= (state == RIGHT) && (rd_cnt < len);
      end else begin
        unique case (state)
          IDLE: begin
            vld_p1       <= 1'b0;
            sel_right_p1 <= 1'b0;
          end
          LEFT: begin
            if (de_in) begin
              if (wr_cnt < MAX_CNT) begin
                vld_p1 <= 1'b1;
                wr_cnt <= wr_cnt + 1'b1;
              end else begin
                vld_p1 <= 1'b0;
                ovf_p1 <= 1'b1;
                if (!ovf_p1) err_p1 <= 1'b1;
              end
            end else begin
              state        <= RIGHT;
              len          <= wr_cnt;
              rd_cnt       <= (ADDR_W+1)'(1);
              vld_p1       <= 1'b1;
              sel_right_p1 <= 1'b1;
              seam_p1      <= 1'b1;
            end
          end
          RIGHT: begin
            if (rd_cnt < len) begin
              rd_cnt <= rd_cnt + 1'b1;
            end else begin
              state        <= IDLE;
              vld_p1       <= 1'b0;
              sel_right_p1 <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign de_out     = vld_p1;
  assign h_sync_out = hs_p1;
  assign v_sync_out = vs_p1;
  assign line_err   = err_p1;
  assign pixel_out  = !vld_p1      ? '0 :
                      sel_right_p1 ? right_px(ram_q, seam_p1) : left_p1;

endmodule

// File: tb/tb_half_img_merge.sv
// Randomized bench for half_img_merge with a line-level reference model and scoreboard.
module tb_half_img_merge;
  localparam int W   = 4;
  localparam int PXW = 8;
  localparam int AW  = 2;
`ifdef HALF_MERGE_SEAM_EN
  localparam bit SEAM = 1'b1;
`else
  localparam bit SEAM = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           de_in, h_sync_in, v_sync_in;
  logic [PXW-1:0] pixel_left, pixel_right;
  logic           de_out, h_sync_out, v_sync_out, line_err;
  logic [PXW-1:0] pixel_out;

  half_img_merge #(.HALF_IMG_W(W), .PX_WIDTH(PXW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_left(pixel_left), .pixel_right(pixel_right), .de_out(de_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
    .line_err(line_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [PXW-1:0] lv[8], rv[8];
  logic [PXW-1:0] exp_q[$], obs_q[$];
  int  rise_q[$], runs_q[$];
  int  cur_run = 0, err_obs = 0, err_exp = 0;
  logic prev_de = 1'b0;
  logic hs_prev = 1'b0, vs_prev = 1'b0;
  bit  hv_valid = 1'b0, sync_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      hs_prev  = h_sync_in;
      vs_prev  = v_sync_in;
      hv_valid = 1'b1;
    end
  end

  always @(negedge rst_n) hv_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hv_valid) begin
        check("hsync_dly", 32'(h_sync_out), 32'(hs_prev));
        check("vsync_dly", 32'(v_sync_out), 32'(vs_prev));
      end
      if (de_out) begin
        obs_q.push_back(pixel_out);
        if (!prev_de) rise_q.push_back(cyc);
        cur_run++;
      end else begin
        check("idle_px", 32'(pixel_out), 32'd0);
        if (prev_de) begin
          runs_q.push_back(cur_run);
          cur_run = 0;
        end
      end
      if (line_err) err_obs++;
      prev_de = de_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (sync_rand) begin
      h_sync_in = 1'($urandom_range(0, 1));
      v_sync_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic rand_px();
    for (int i = 0; i < 8; i++) begin
      lv[i] = 8'($urandom);
      rv[i] = 8'($urandom);
    end
  endtask

  // Model: first min(n,W) left pixels, then the stored right pixels; a blanking
  // shorter than the stored length truncates the readout to one pixel per blank cycle.
  task automatic send_line(input int n, input int blank);
    int cap, rsh;
    cap = (n < W) ? n : W;
    rsh = (blank < cap) ? blank : cap;
    for (int i = 0; i < cap; i++) exp_q.push_back(lv[i]);
    for (int i = 0; i < rsh; i++) exp_q.push_back((i == 0 && SEAM) ? 8'hFF : rv[i]);
    if (n > W) err_exp++;
    if (blank < cap) err_exp++;
    for (int i = 0; i < n; i++) begin
      de_in = 1'b1;
      pixel_left = lv[i];
      pixel_right = rv[i];
      step();
    end
    de_in = 1'b0;
    pixel_left = '0;
    pixel_right = '0;
    repeat (blank) step();
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    rise_q.delete();
    runs_q.delete();
    cur_run = 0;
    err_obs = 0;
    err_exp = 0;
  endtask

  task automatic compare_sb(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check({tag, "_px"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_line_err"}, 32'(err_obs), 32'(err_exp));
  endtask

  task automatic check_runs(input string tag, input int a, input int b);
    int n;
    n = (b > 0) ? 2 : 1;
    check({tag, "_runs"}, 32'(runs_q.size()), 32'(n));
    if (runs_q.size() > 0) check({tag, "_run0"}, 32'(runs_q[0]), 32'(a));
    if (b > 0 && runs_q.size() > 1) check({tag, "_run1"}, 32'(runs_q[1]), 32'(b));
  endtask

  initial begin
    int t0, n, cap, blank;
    de_in = 1'b0;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    pixel_left = '0;
    pixel_right = '0;
    repeat (3) step();
    check("rst_de_out", 32'(de_out), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_hsync", 32'(h_sync_out), 32'd0);
    check("rst_vsync", 32'(v_sync_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Basic merge
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      lv[i] = 8'(i + 1);
      rv[i] = 8'(i + 11);
    end
    t0 = cyc;
    send_line(4, 8);
    if (rise_q.size() > 0) check("basic_latency", 32'(rise_q[0]), 32'(t0 + 1));
    else check("basic_latency", 32'd0, 32'd1);
    check_runs("basic", 8, 0);
    compare_sb("basic");

    // Short line
    clear_sb();
    lv[0] = 8'd5; lv[1] = 8'd6; rv[0] = 8'd7; rv[1] = 8'd8;
    send_line(2, 8);
    check_runs("short", 4, 0);
    compare_sb("short");

    // Overlong line: two dropped pairs leave a gap in de_out
    clear_sb();
    rand_px();
    send_line(6, 8);
    check_runs("overlong", 4, 4);
    compare_sb("overlong");

    // Collision: blanking of 2 cuts the right readout to 2 pixels
    clear_sb();
    rand_px();
    send_line(4, 2);
    rand_px();
    send_line(4, 8);
    check_runs("collide", 14, 0);
    compare_sb("collide");

    // Reset in the middle of the right readout
    clear_sb();
    rand_px();
    for (int i = 0; i < 4; i++) begin
      de_in = 1'b1;
      pixel_left = lv[i];
      pixel_right = rv[i];
      step();
    end
    de_in = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_de_out", 32'(de_out), 32'd0);
    check("rstmid_pixel", 32'(pixel_out), 32'd0);
    check("rstmid_line_err", 32'(line_err), 32'd0);
    check("rstmid_hsync", 32'(h_sync_out), 32'd0);
    check("rstmid_vsync", 32'(v_sync_out), 32'd0);
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    prev_de = 1'b0;
    clear_sb();
    rand_px();
    send_line(4, 8);
    check_runs("after_rst", 8, 0);
    compare_sb("after_rst");

    // Random lines with legal blanking and toggling syncs
    clear_sb();
    sync_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      rand_px();
      n = int'($urandom_range(1, 6));
      cap = (n < W) ? n : W;
      blank = int'($urandom_range(cap, cap + 3));
      send_line(n, blank);
    end
    rand_px();
    send_line(int'($urandom_range(1, 4)), 10);
    sync_rand = 1'b0;
    h_sync_in = 1'b0;
    v_sync_in = 1'b0;
    repeat (4) step();
    compare_sb("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
